subtractor_32bit_seq: RTL and testbench
=======================================

// Module: subtractor_32bit_seq
// PURPOSE
//  Sequential 32-bit subtractor for the ULA: computes Diff = A - B one 8-bit slice per cycle,
//  LSB slice first, with a registered borrow chain between slices. Inverse operation of the
//  32-bit adder datapath. Operands are accepted and results delivered over valid/ready
//  handshakes, so the ULA control logic can stall either side.
// PARAMETERS
//  WIDTH  32  operand/result width; must be a multiple of SLICE
//  SLICE   8  bits processed per cycle; N = WIDTH/SLICE slices (default N=4)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operands A/B valid
//  in_ready   out  1      block can accept operands (high only in IDLE)
//  A          in   WIDTH  minuend, sampled on the accept edge
//  B          in   WIDTH  subtrahend, sampled on the accept edge
//  out_valid  out  1      result valid (high only in DONE)
//  out_ready  in   1      consumer takes the result
//  Diff       out  WIDTH  A - B modulo 2^WIDTH
//  Bout       out  1      unsigned borrow: 1 iff A < B (unsigned)
//  Ovf        out  1      signed overflow: A[MSB]!=B[MSB] && Diff[MSB]!=A[MSB]
//  Zero       out  1      Diff == 0
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; in_ready=1; out_valid=0; Diff/Bout/Ovf/Zero=0;
//    slice counter=0; internal carry=1. Reset mid-operation aborts and discards the operation.
//  - States: IDLE -> RUN on in_valid&&in_ready (accept edge: latch A,B, cnt=0, carry=1).
//    RUN -> DONE on the edge processing slice cnt==N-1. DONE -> IDLE on out_valid&&out_ready.
//  - Per RUN cycle: {c,s} = A[k] + ~B[k] + carry (k = slice cnt); Diff[k] <= s; carry <= c;
//    cnt <= cnt+1. Two's-complement subtraction, no separate borrow logic.
//  - On the last slice edge: Bout <= ~c; Ovf and Zero computed from the final operands/Diff
//    and registered together with the transition to DONE.
//  - Latency: out_valid rises exactly N cycles after the accept edge (4 with defaults).
//  - in_ready=0 during RUN and DONE; in_valid there is ignored (no capture, no queuing).
//    No back-to-back acceptance: the earliest next accept is the cycle after DONE->IDLE.
//  - DONE holds Diff/Bout/Ovf/Zero and out_valid stable indefinitely while out_ready=0.
//  - After DONE->IDLE, result outputs keep their last values (out_valid=0) until the next
//    operation overwrites them; Diff slices may change during RUN and are valid only with out_valid.
//  - out_ready while not in DONE has no effect. A, B may change freely after the accept edge.
//  - Widths: all arithmetic modulo 2^WIDTH; inter-slice carry is 1 bit, never wider.
// TESTING
//  1. A=5, B=3 -> out_valid 4 cycles after accept; Diff=0x00000002, Bout=0, Ovf=0, Zero=0.
//  2. A=3, B=5 -> Diff=0xFFFFFFFE, Bout=1, Ovf=0, Zero=0.
//  3. A=0x00000100, B=1 -> Diff=0x000000FF (borrow crosses slice 0->1), Bout=0.
//  4. A=0x80000000, B=1 -> Diff=0x7FFFFFFF, Ovf=1, Bout=0; A=B=0x12345678 -> Diff=0, Zero=1.
//  5. out_ready=0 for 3 cycles in DONE -> out_valid and Diff held; in_valid pulses in RUN/DONE
//     ignored (in_ready=0); accept again only after out_ready handshake.
//  6. rst_n low during RUN (cnt=2) -> immediately IDLE, in_ready=1, out_valid=0, Diff=0;
//     next op A=10, B=4 completes normally with Diff=6.

Source files
------------

// File: rtl/subtractor_32bit_seq.sv
// Sequential WIDTH-bit subtractor: one SLICE-bit slice per cycle, LSB first,
// with a registered borrow (inverted carry) chain between slices.
module subtractor_32bit_seq #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Ovf,
    output logic             Zero
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE:0]   sum;

    // A + ~B + carry on the current slice; carry starts at 1 for two's complement.
    always_comb begin
        a_sl = a_q[cnt_q*SLICE +: SLICE];
        b_sl = b_q[cnt_q*SLICE +: SLICE];
        sum  = {1'b0, a_sl} + {1'b0, ~b_sl} + {{SLICE{1'b0}}, carry_q};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    cnt_d   = '0;
                    carry_d = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                diff_d[cnt_q*SLICE +: SLICE] = sum[SLICE-1:0];
                carry_d = sum[SLICE];
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    bout_d  = ~sum[SLICE];
                    ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                              (sum[SLICE-1] != a_q[WIDTH-1]);
                    zero_d  = (diff_d == '0);
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b1;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign Diff      = diff_q;
    assign Bout      = bout_q;
    assign Ovf       = ovf_q;
    assign Zero      = zero_q;

endmodule

// File: tb/tb_subtractor_32bit_seq.sv
// Scoreboard bench for subtractor_32bit_seq: directed operands with
// hand-computed results, latency/stall/reset checks.
module tb_subtractor_32bit_seq;

    typedef struct packed {
        logic [31:0] diff;
        logic        bout;
        logic        ovf;
        logic        zero;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Diff;
    logic        Bout;
    logic        Ovf;
    logic        Zero;

    int   n_pass;
    int   n_total;
    exp_t sb[$];

    subtractor_32bit_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Diff      (Diff),
        .Bout      (Bout),
        .Ovf       (Ovf),
        .Zero      (Zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every output handshake pops one expected result.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL sb_unexpected: got result 0x%08h expected none", Diff);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_diff", Diff, e.diff);
                chk("sb_bout", {31'b0, Bout}, {31'b0, e.bout});
                chk("sb_ovf",  {31'b0, Ovf},  {31'b0, e.ovf});
                chk("sb_zero", {31'b0, Zero}, {31'b0, e.zero});
            end
        end
    end

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input exp_t e, input int hold, input bit noise);
        int          lat;
        logic [31:0] d0;
        @(negedge clk);
        A         = a;
        B         = b;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        chk("accept_ready", {31'b0, in_ready}, 32'd1);
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (noise) begin
            A = ~a;
            B = ~b;
        end else begin
            in_valid = 1'b0;
        end
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
            if (noise) chk("run_in_ready", {31'b0, in_ready}, 32'd0);
        end
        chk("latency", lat, 32'd4);
        if (hold > 0) begin
            d0 = Diff;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                chk("hold_valid", {31'b0, out_valid}, 32'd1);
                chk("hold_diff", Diff, d0);
                chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post_valid", {31'b0, out_valid}, 32'd0);
        chk("post_ready", {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        n_pass    = 0;
        n_total   = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        A         = '0;
        B         = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_diff", Diff, 32'd0);
        chk("rst_flags", {29'b0, Bout, Ovf, Zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(32'd5, 32'd3, '{32'h0000_0002, 1'b0, 1'b0, 1'b0}, 0, 1'b0);
        run_op(32'd3, 32'd5, '{32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0}, 0, 1'b0);
        run_op(32'h0000_0100, 32'd1,
               '{32'h0000_00FF, 1'b0, 1'b0, 1'b0}, 0, 1'b0);
        run_op(32'h8000_0000, 32'd1,
               '{32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0}, 0, 1'b0);
        run_op(32'h1234_5678, 32'h1234_5678,
               '{32'h0000_0000, 1'b0, 1'b0, 1'b1}, 0, 1'b0);
        run_op(32'h0000_0000, 32'h0000_0001,
               '{32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0}, 0, 1'b0);
        run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF,
               '{32'h8000_0000, 1'b1, 1'b1, 1'b0}, 3, 1'b1);

        // Abort an operation with reset at slice count 2.
        @(negedge clk);
        A        = 32'hFFFF_FFFF;
        B        = 32'h0000_0000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
        chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
        chk("abort_diff", Diff, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(32'd10, 32'd4, '{32'h0000_0006, 1'b0, 1'b0, 1'b0}, 0, 1'b0);

        repeat (3) @(posedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
